// File: rtl/hsk_fifo_mc.sv
// ---------------------------------------------------------------------------
// hsk_fifo_mc
//
// Multi-channel req/ack FIFO: CH independent queues of DEPTH entries each,
// sharing one push port and one pop port, each addressed by a channel index.
// Every channel keeps its own write/read pointer, occupancy counter,
// full/empty flags and, optionally, an idle-timeout flag.
//
// Build option:
//   HSK_FIFO_MC_TIMEOUT_EN  defined   -> per-channel idle counters drive
//                                        timeout[c] after TO_CYCLES idle
//                                        cycles on a non-empty channel.
//                           undefined -> timeout tied to zero, no idle
//                                        counters, TO_CYCLES ignored.
//
// Ports:
//   clk       in   clock, rising edge
//   resetn    in   asynchronous active-low reset
//   push_req  in   producer write request
//   push_ch   in   [CHW]   target channel of push
//   data_in   in   [WIDTH] write data
//   push_ack  out  write accepted this cycle (combinational)
//   pop_req   in   consumer read request
//   pop_ch    in   [CHW]   source channel of pop
//   pop_ack   out  read accepted this cycle (combinational)
//   data_out  out  [WIDTH] read data, registered, valid the cycle after pop
//   full      out  [CH]    channel holds DEPTH entries
//   empty     out  [CH]    channel holds 0 entries
//   count     out  [CH*(L2D+1)] occupancy, channel c at [c*(L2D+1) +: L2D+1]
//   timeout   out  [CH]    channel idle for TO_CYCLES cycles
// ---------------------------------------------------------------------------
module hsk_fifo_mc #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int L2D       = 4,
    parameter int CH        = 4,
    parameter int CHW       = 2,
    parameter int TO_CYCLES = 7
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    push_req,
    input  logic [CHW-1:0]          push_ch,
    input  logic [WIDTH-1:0]        data_in,
    output logic                    push_ack,
    input  logic                    pop_req,
    input  logic [CHW-1:0]          pop_ch,
    output logic                    pop_ack,
    output logic [WIDTH-1:0]        data_out,
    output logic [CH-1:0]           full,
    output logic [CH-1:0]           empty,
    output logic [CH*(L2D+1)-1:0]   count,
    output logic [CH-1:0]           timeout
);

    localparam int CW = L2D + 1;

    // Parameter sanity: an illegal combination elaborates this empty
    // scope, which makes a misconfigured instance easy to spot in the
    // hierarchy. The legal configuration never creates it.
    generate
        if ((DEPTH != (1 << L2D)) || (DEPTH < 2) || (CH < 2) ||
            ((1 << CHW) < CH) || (TO_CYCLES < 1) || (TO_CYCLES > 255)) begin : g_illegal_params
        end
    endgenerate

    // Storage is deliberately not reset.
    logic [WIDTH-1:0] r_mem   [CH][DEPTH];
    logic [L2D-1:0]   r_wptr  [CH];
    logic [L2D-1:0]   r_rptr  [CH];
    logic [CW-1:0]    r_count [CH];
    logic [WIDTH-1:0] r_data_out;

    logic [CH-1:0]    w_full;
    logic [CH-1:0]    w_empty;
    logic [CH-1:0]    w_push_sel;
    logic [CH-1:0]    w_pop_sel;
    logic             w_push_ch_ok;
    logic             w_pop_ch_ok;
    logic             w_push_hsk;
    logic             w_pop_hsk;

    // -----------------------------------------------------------------------
    // Flags and handshakes, all derived from registered occupancy so that
    // push never sees a same-cycle pop and pop never sees a same-cycle push.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            w_full[c]  = (r_count[c] == CW'(DEPTH));
            w_empty[c] = (r_count[c] == '0);
        end
    end

    // Channel indices beyond CH (only possible when CH is not a power of
    // two) are refused rather than aliased onto another queue.
    assign w_push_ch_ok = (32'(push_ch) < 32'(CH));
    assign w_pop_ch_ok  = (32'(pop_ch)  < 32'(CH));

    assign push_ack   = push_req && w_push_ch_ok && !w_full[push_ch];
    assign pop_ack    = pop_req  && w_pop_ch_ok  && !w_empty[pop_ch];
    assign w_push_hsk = push_ack;
    assign w_pop_hsk  = pop_ack;

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            w_push_sel[c] = w_push_hsk && (push_ch == CHW'(c));
            w_pop_sel[c]  = w_pop_hsk  && (pop_ch  == CHW'(c));
        end
    end

    // -----------------------------------------------------------------------
    // Storage write
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push_hsk) begin
            r_mem[push_ch][r_wptr[push_ch]] <= data_in;
        end
    end

    // -----------------------------------------------------------------------
    // Pointers and occupancy. A same-channel push+pop advances both
    // pointers and leaves the count alone.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < CH; c++) begin
                r_wptr[c]  <= '0;
                r_rptr[c]  <= '0;
                r_count[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (w_push_sel[c]) begin
                    r_wptr[c] <= r_wptr[c] + 1'b1;
                end
                if (w_pop_sel[c]) begin
                    r_rptr[c] <= r_rptr[c] + 1'b1;
                end
                case ({w_push_sel[c], w_pop_sel[c]})
                    2'b10:   r_count[c] <= r_count[c] + 1'b1;
                    2'b01:   r_count[c] <= r_count[c] - 1'b1;
                    default: r_count[c] <= r_count[c];
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read data register: holds its value between pops.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data_out <= '0;
        end else if (w_pop_hsk) begin
            r_data_out <= r_mem[pop_ch][r_rptr[pop_ch]];
        end
    end

    assign data_out = r_data_out;
    assign full     = w_full;
    assign empty    = w_empty;

    always_comb begin
        count = '0;
        for (int c = 0; c < CH; c++) begin
            count[c*CW +: CW] = r_count[c];
        end
    end

    // -----------------------------------------------------------------------
    // Idle timeout
    // -----------------------------------------------------------------------
`ifdef HSK_FIFO_MC_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TO_CYCLES);

    logic [7:0]    r_idle [CH];
    logic [7:0]    w_idle_nxt [CH];
    logic [CH-1:0] r_timeout;

    // Any handshake on the channel, or the channel sitting empty, restarts
    // the idle count; otherwise it climbs and parks at the limit.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            if (w_empty[c] || w_push_sel[c] || w_pop_sel[c]) begin
                w_idle_nxt[c] = '0;
            end else if (r_idle[c] != TO_LIM) begin
                w_idle_nxt[c] = r_idle[c] + 8'd1;
            end else begin
                w_idle_nxt[c] = r_idle[c];
            end
        end
    end

    // The flag is registered from the next idle value so it rises on the
    // same edge the counter reaches the limit, TO_CYCLES edges after the
    // last handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < CH; c++) begin
                r_idle[c] <= '0;
            end
            r_timeout <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                r_idle[c]    <= w_idle_nxt[c];
                r_timeout[c] <= (w_idle_nxt[c] == TO_LIM);
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = {CH{1'b0}};
`endif

endmodule

// File: tb/tb_hsk_fifo_mc.sv
module tb_hsk_fifo_mc;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int L2D   = 4;
    localparam int CH    = 4;
    localparam int CHW   = 2;
    localparam int TO_C  = 7;
    localparam int CW    = L2D + 1;

    logic                  clk;
    logic                  resetn;
    logic                  push_req;
    logic [CHW-1:0]        push_ch;
    logic [WIDTH-1:0]      data_in;
    logic                  push_ack;
    logic                  pop_req;
    logic [CHW-1:0]        pop_ch;
    logic                  pop_ack;
    logic [WIDTH-1:0]      data_out;
    logic [CH-1:0]         full;
    logic [CH-1:0]         empty;
    logic [CH*CW-1:0]      count;
    logic [CH-1:0]         timeout;

    int n_total  = 0;
    int n_passed = 0;

    hsk_fifo_mc #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .L2D(L2D),
        .CH(CH), .CHW(CHW), .TO_CYCLES(TO_C)
    ) dut (
        .clk(clk), .resetn(resetn),
        .push_req(push_req), .push_ch(push_ch), .data_in(data_in),
        .push_ack(push_ack),
        .pop_req(pop_req), .pop_ch(pop_ch), .pop_ack(pop_ack),
        .data_out(data_out),
        .full(full), .empty(empty), .count(count), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] cnt(input int c);
        return count[c*CW +: CW];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one full cycle; inputs are driven and outputs sampled at negedge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [CH-1:0] exp_to;

    initial begin
        resetn   = 1'b0;
        push_req = 1'b0;
        push_ch  = '0;
        data_in  = '0;
        pop_req  = 1'b0;
        pop_ch   = '0;
        cyc();
        cyc();

        // Reset state
        chk("rst_empty",    32'(empty),    32'hF);
        chk("rst_full",     32'(full),     32'h0);
        chk("rst_count",    32'(count),    32'h0);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_timeout",  32'(timeout),  32'h0);
        resetn = 1'b1;
        cyc();

        // Single push/pop on ch 2
        push_req = 1'b1; push_ch = 2'd2; data_in = 8'hA5;
        #1 chk("t1_push_ack", 32'(push_ack), 32'h1);
        cyc();
        push_req = 1'b0;
        chk("t1_count2", 32'(cnt(2)),   32'd1);
        chk("t1_empty2", 32'(empty[2]), 32'h0);
        pop_req = 1'b1; pop_ch = 2'd2;
        #1 chk("t1_pop_ack", 32'(pop_ack), 32'h1);
        cyc();
        pop_req = 1'b0;
        chk("t1_data_out", 32'(data_out), 32'hA5);
        chk("t1_empty2b",  32'(empty[2]), 32'h1);

        // Fill ch 1, refuse 17th, drain in order
        push_ch = 2'd1;
        for (int i = 0; i < DEPTH; i++) begin
            push_req = 1'b1; data_in = 8'(i);
            cyc();
        end
        chk("t2_full1",  32'(full[1]), 32'h1);
        chk("t2_count1", 32'(cnt(1)),  32'd16);
        data_in = 8'h10;
        #1 chk("t2_push_ack_full", 32'(push_ack), 32'h0);
        cyc();
        chk("t2_count1_held", 32'(cnt(1)), 32'd16);
        push_req = 1'b0;
        pop_ch = 2'd1;
        for (int i = 0; i < DEPTH; i++) begin
            pop_req = 1'b1;
            cyc();
            chk($sformatf("t2_pop%0d", i), 32'(data_out), 32'(i));
        end
        pop_req = 1'b0;
        chk("t2_empty1", 32'(empty[1]), 32'h1);

        // Ch 0 with 3 entries, then 20 cycles of concurrent push+pop
        push_ch = 2'd0;
        for (int i = 0; i < 3; i++) begin
            push_req = 1'b1; data_in = 8'(8'h30 + i);
            cyc();
        end
        pop_ch = 2'd0;
        for (int k = 0; k < 20; k++) begin
            push_req = 1'b1; data_in = 8'(8'h33 + k);
            pop_req  = 1'b1;
            #1 chk($sformatf("t3_acks%0d", k), 32'({push_ack, pop_ack}), 32'h3);
            cyc();
            chk($sformatf("t3_data%0d", k), 32'(data_out), 32'(8'h30 + k));
            chk($sformatf("t3_count%0d", k), 32'(cnt(0)), 32'd3);
        end
        push_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("t3_drain%0d", k), 32'(data_out), 32'(8'h44 + k));
        end
        pop_req = 1'b0;
        chk("t3_empty0", 32'(empty[0]), 32'h1);

        // Pop on empty ch 3 with same-cycle push: no bypass
        push_req = 1'b1; push_ch = 2'd3; data_in = 8'h77;
        pop_req  = 1'b1; pop_ch  = 2'd3;
        #1 chk("t4_pop_ack0",  32'(pop_ack),  32'h0);
        chk("t4_push_ack", 32'(push_ack), 32'h1);
        cyc();
        push_req = 1'b0;
        #1 chk("t4_pop_ack1", 32'(pop_ack), 32'h1);
        cyc();
        pop_req = 1'b0;
        chk("t4_data_out", 32'(data_out), 32'h77);

        // Idle timeout on ch 0
        push_req = 1'b1; push_ch = 2'd0; data_in = 8'h5A;
        cyc();
        push_req = 1'b0;
        chk("t5_to_at0", 32'(timeout), 32'h0);
        for (int k = 1; k <= 9; k++) begin
            cyc();
`ifdef HSK_FIFO_MC_TIMEOUT_EN
            exp_to = (k >= TO_C) ? 4'b0001 : 4'b0000;
`else
            exp_to = 4'b0000;
`endif
            chk($sformatf("t5_to_at%0d", k), 32'(timeout), 32'(exp_to));
        end
        pop_req = 1'b1; pop_ch = 2'd0;
        cyc();
        pop_req = 1'b0;
        chk("t5_to_after_pop", 32'(timeout),  32'h0);
        chk("t5_data_out",     32'(data_out), 32'h5A);

        // Asynchronous reset mid-operation
        push_ch = 2'd1;
        for (int i = 0; i < 5; i++) begin
            push_req = 1'b1; data_in = 8'(8'h60 + i);
            cyc();
        end
        push_req = 1'b0;
        chk("t6_count1_pre", 32'(cnt(1)), 32'd5);
        pop_req = 1'b1; pop_ch = 2'd1;
        #1 chk("t6_pop_ack_pre", 32'(pop_ack), 32'h1);
        #1 resetn = 1'b0;
        #1;
        chk("t6_count1",   32'(cnt(1)),   32'd0);
        chk("t6_empty",    32'(empty),    32'hF);
        chk("t6_data_out", 32'(data_out), 32'h0);
        chk("t6_pop_ack",  32'(pop_ack),  32'h0);
        @(negedge clk);
        pop_req = 1'b0;
        resetn  = 1'b1;
        cyc();
        chk("t6_count_all", 32'(count), 32'h0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
